// File: rtl/id_stage.sv
// Decode / operand-fetch stage of the 3-stage 16-bit pipeline: register file,
// instruction decode, RAW stall/forward and write-back of execute results.
module id_stage #(
    parameter int         DATA_W = 16,
    parameter int         RA_W   = 3,
    parameter logic [3:0] NOP_OP = 4'hF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [DATA_W-1:0] ex_result,
    output logic [DATA_W-1:0] data1,
    output logic [DATA_W-1:0] data2,
    output logic [3:0]        opcode,
    input  logic [RA_W-1:0]   dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int NREGS = 2 ** RA_W;

    logic [DATA_W-1:0] r_regs [NREGS];
    logic              r_ex_valid;
    logic [RA_W-1:0]   r_ex_rd;
    logic              r_wb_valid;
    logic [RA_W-1:0]   r_wb_rd;

    logic [3:0]        w_op;
    logic [RA_W-1:0]   w_rd;
    logic [RA_W-1:0]   w_rs1;
    logic [RA_W-1:0]   w_rs2;
    logic              w_is_alu;
    logic              w_is_ldi;
    logic              w_hazard;
    logic              w_accept;
    logic [DATA_W-1:0] w_op1;
    logic [DATA_W-1:0] w_op2;
    logic [DATA_W-1:0] w_imm;

    assign w_op     = instr[15:12];
    assign w_rd     = instr[11:9];
    assign w_rs1    = instr[8:6];
    assign w_rs2    = instr[5:3];
    assign w_is_alu = (w_op <= 4'd4);
    assign w_is_ldi = (w_op == 4'h8);
    assign w_imm    = {{(DATA_W-9){1'b0}}, instr[8:0]};

    // A source that the instruction now in execute will write is not ready yet: one bubble.
    assign w_hazard    = w_is_alu && r_ex_valid && (r_ex_rd != {RA_W{1'b0}}) &&
                         ((w_rs1 == r_ex_rd) || (w_rs2 == r_ex_rd));
    assign instr_ready = !w_hazard;
    assign w_accept    = instr_valid && instr_ready;

    assign dbg_data = r_regs[dbg_addr];

    // Operand fetch: r0 reads zero, the write-back value beats the stale regfile entry.
    always_comb begin
        w_op1 = {DATA_W{1'b0}};
        w_op2 = {DATA_W{1'b0}};
        if (w_rs1 == {RA_W{1'b0}}) begin
            w_op1 = {DATA_W{1'b0}};
        end else if (r_wb_valid && (r_wb_rd == w_rs1)) begin
            w_op1 = ex_result;
        end else begin
            w_op1 = r_regs[w_rs1];
        end
        if (w_rs2 == {RA_W{1'b0}}) begin
            w_op2 = {DATA_W{1'b0}};
        end else if (r_wb_valid && (r_wb_rd == w_rs2)) begin
            w_op2 = ex_result;
        end else begin
            w_op2 = r_regs[w_rs2];
        end
    end

    // Issue registers toward execute plus the execute/write-back tracking pipeline.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data1      <= {DATA_W{1'b0}};
            data2      <= {DATA_W{1'b0}};
            opcode     <= NOP_OP;
            r_ex_valid <= 1'b0;
            r_ex_rd    <= {RA_W{1'b0}};
            r_wb_valid <= 1'b0;
            r_wb_rd    <= {RA_W{1'b0}};
        end else begin
            r_wb_valid <= r_ex_valid;
            r_wb_rd    <= r_ex_rd;
            if (w_accept) begin
                r_ex_valid <= w_is_alu || w_is_ldi;
                r_ex_rd    <= w_rd;
                if (w_is_ldi) begin
                    data1  <= w_imm;
                    data2  <= {DATA_W{1'b0}};
                    opcode <= 4'h0;
                end else if (w_is_alu) begin
                    data1  <= w_op1;
                    data2  <= w_op2;
                    opcode <= w_op;
                end else begin
                    opcode <= NOP_OP;
                end
            end else begin
                r_ex_valid <= 1'b0;
                opcode     <= NOP_OP;
            end
        end
    end

    // Register file write-back; r0 is never written so it stays zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= {DATA_W{1'b0}};
            end
        end else if (r_wb_valid && (r_wb_rd != {RA_W{1'b0}})) begin
            r_regs[r_wb_rd] <= ex_result;
        end else begin
            r_regs <= r_regs;
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed vector table, mid-stream reset, then random
// instruction streams checked against an architectural (sequential) model.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] instr = 16'hF000;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [15:0] ex_result;
    logic [15:0] data1, data2, dbg_data;
    logic [3:0]  opcode;
    logic [2:0]  dbg_addr = 3'd0;

    int n_tests = 0;
    int n_fail  = 0;

    id_stage dut (
        .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .ex_result(ex_result), .data1(data1),
        .data2(data2), .opcode(opcode), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] alu(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            default: return 16'h0;
        endcase
    endfunction

    // Execute stage stand-in: result registered one edge after issue.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ex_result <= 16'h0;
        else      ex_result <= alu(opcode, data1, data2);
    end

    function automatic logic [15:0] mk_alu(input logic [3:0] op, input int rd, input int rs1, input int rs2);
        logic [2:0] a, b, c;
        a = rd[2:0]; b = rs1[2:0]; c = rs2[2:0];
        return {op, a, b, c, 3'b000};
    endfunction

    function automatic logic [15:0] mk_ldi(input int rd, input int imm);
        logic [2:0] a;
        logic [8:0] v;
        a = rd[2:0]; v = imm[8:0];
        return {4'h8, a, v};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [15:0] instr;
        logic        valid;
        logic        exp_ready;
        logic [3:0]  exp_op;
        logic        chk_data;
        logic [15:0] exp_d1;
        logic [15:0] exp_d2;
    } vec_t;

    function automatic vec_t mk_vec(input logic [15:0] i, input logic v, input logic rdy,
                                    input logic [3:0] op, input logic cd, input logic [15:0] d1, input logic [15:0] d2);
        vec_t r;
        r.instr = i; r.valid = v; r.exp_ready = rdy; r.exp_op = op;
        r.chk_data = cd; r.exp_d1 = d1; r.exp_d2 = d2;
        return r;
    endfunction

    vec_t        vecs [13];
    logic [15:0] exp_regs [8];
    logic [15:0] arch [8];

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            instr = 16'hF000;
            instr_valid = 1'b0;
        end
    endtask

    task automatic check_regs(input string tag);
        for (int r = 0; r < 8; r++) begin
            dbg_addr = r[2:0];
            #1;
            check($sformatf("%s_r%0d", tag, r), {16'h0, dbg_data}, {16'h0, arch[r]});
        end
    endtask

    // Random-phase model state
    logic [15:0] cur;
    logic        holding, acc, prev_wr, exp_stall, is_alu, is_ldi;
    logic [2:0]  prev_rd, rd, rs1, rs2;
    logic [3:0]  op, exp_op;
    logic [15:0] e1, e2;
    logic [3:0]  nop_ops [10] = '{4'h5, 4'h6, 4'h7, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};

    initial begin
        vecs[0]  = mk_vec(mk_ldi(1, 5),           1'b1, 1'b1, 4'h0, 1'b1, 16'd5, 16'd0);
        vecs[1]  = mk_vec(mk_ldi(2, 3),           1'b1, 1'b1, 4'h0, 1'b1, 16'd3, 16'd0);
        vecs[2]  = mk_vec(mk_alu(4'h0, 3, 1, 2),  1'b1, 1'b0, 4'hF, 1'b0, 16'd0, 16'd0);
        vecs[3]  = mk_vec(mk_alu(4'h0, 3, 1, 2),  1'b1, 1'b1, 4'h0, 1'b1, 16'd5, 16'd3);
        vecs[4]  = mk_vec(16'hC000,               1'b0, 1'b1, 4'hF, 1'b0, 16'd0, 16'd0);
        vecs[5]  = mk_vec(mk_alu(4'h1, 4, 3, 1),  1'b1, 1'b1, 4'h1, 1'b1, 16'd8, 16'd5);
        vecs[6]  = mk_vec(mk_alu(4'h4, 5, 4, 4),  1'b1, 1'b0, 4'hF, 1'b0, 16'd0, 16'd0);
        vecs[7]  = mk_vec(mk_alu(4'h4, 5, 4, 4),  1'b1, 1'b1, 4'h4, 1'b1, 16'd3, 16'd3);
        vecs[8]  = mk_vec(mk_ldi(0, 7),           1'b1, 1'b1, 4'h0, 1'b1, 16'd7, 16'd0);
        vecs[9]  = mk_vec(mk_alu(4'h0, 6, 0, 0),  1'b1, 1'b1, 4'h0, 1'b1, 16'd0, 16'd0);
        vecs[10] = mk_vec(mk_ldi(7, 9),           1'b1, 1'b1, 4'h0, 1'b1, 16'd9, 16'd0);
        vecs[11] = mk_vec(mk_alu(4'hC, 2, 7, 7),  1'b1, 1'b1, 4'hF, 1'b0, 16'd0, 16'd0);
        vecs[12] = mk_vec(mk_alu(4'h3, 1, 7, 7),  1'b1, 1'b1, 4'h3, 1'b1, 16'd9, 16'd9);
        arch = '{16'd0, 16'd9, 16'd3, 16'd8, 16'd3, 16'd0, 16'd0, 16'd9};

        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_opcode", {28'h0, opcode}, 32'hF);
        check("rst_data1", {16'h0, data1}, 32'h0);
        check("rst_ready", {31'h0, instr_ready}, 32'h1);

        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            instr = vecs[i].instr;
            instr_valid = vecs[i].valid;
            #1;
            check($sformatf("vec%0d_ready", i), {31'h0, instr_ready}, {31'h0, vecs[i].exp_ready});
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_opcode", i), {28'h0, opcode}, {28'h0, vecs[i].exp_op});
            if (vecs[i].chk_data) begin
                check($sformatf("vec%0d_data1", i), {16'h0, data1}, {16'h0, vecs[i].exp_d1});
                check($sformatf("vec%0d_data2", i), {16'h0, data2}, {16'h0, vecs[i].exp_d2});
            end
        end
        idle_cycles(3);
        check_regs("vec");

        // Reset while LDI r3 is in flight: it must never reach the regfile.
        @(negedge clk);
        instr = mk_ldi(3, 100);
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        instr = mk_alu(4'h0, 4, 3, 3);
        instr_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("mrst_data1", {16'h0, data1}, 32'h0);
        check("mrst_data2", {16'h0, data2}, 32'h0);
        check("mrst_opcode", {28'h0, opcode}, 32'hF);
        check("mrst_ready", {31'h0, instr_ready}, 32'h1);
        for (int r = 0; r < 8; r++) arch[r] = 16'h0;
        check_regs("mrst_in");
        @(negedge clk);
        rst = 1'b1;
        idle_cycles(3);
        check_regs("mrst_after");

        // Random streams against a sequential architectural model.
        holding = 1'b0;
        prev_wr = 1'b0;
        prev_rd = 3'd0;
        cur = 16'hF000;
        for (int blk = 0; blk < 4; blk++) begin
            for (int c = 0; c < 150; c++) begin
                @(negedge clk);
                if (!holding) begin
                    int k;
                    k = $urandom_range(0, 9);
                    cur = $urandom;
                    if (k <= 5)      cur[15:12] = 4'($urandom_range(0, 4));
                    else if (k <= 7) cur[15:12] = 4'h8;
                    else             cur[15:12] = nop_ops[$urandom_range(0, 9)];
                    instr_valid = ($urandom_range(0, 3) != 0);
                end
                instr = cur;
                op = cur[15:12]; rd = cur[11:9]; rs1 = cur[8:6]; rs2 = cur[5:3];
                is_alu = (op <= 4'd4);
                is_ldi = (op == 4'h8);
                exp_stall = is_alu && prev_wr && (prev_rd != 3'd0) && (rs1 == prev_rd || rs2 == prev_rd);
                #1;
                check("rnd_ready", {31'h0, instr_ready}, {31'h0, !exp_stall});
                acc = instr_valid && !exp_stall;
                exp_op = 4'hF;
                e1 = 16'h0;
                e2 = 16'h0;
                if (acc && is_alu) begin
                    e1 = arch[rs1];
                    e2 = arch[rs2];
                    exp_op = op;
                    if (rd != 3'd0) arch[rd] = alu(op, e1, e2);
                end else if (acc && is_ldi) begin
                    e1 = {7'h0, cur[8:0]};
                    exp_op = 4'h0;
                    if (rd != 3'd0) arch[rd] = e1;
                end
                prev_wr = acc && (is_alu || is_ldi);
                prev_rd = rd;
                holding = instr_valid && exp_stall;
                @(posedge clk);
                #1;
                check("rnd_opcode", {28'h0, opcode}, {28'h0, exp_op});
                if (acc && (is_alu || is_ldi)) begin
                    check("rnd_data1", {16'h0, data1}, {16'h0, e1});
                    check("rnd_data2", {16'h0, data2}, {16'h0, e2});
                end
            end
            if (holding) begin
                @(negedge clk);
                instr = cur;
                instr_valid = 1'b1;
                #1;
                check("rnd_unstall", {31'h0, instr_ready}, 32'h1);
                if (is_alu && rd != 3'd0) arch[rd] = alu(op, arch[rs1], arch[rs2]);
                holding = 1'b0;
            end
            idle_cycles(3);
            prev_wr = 1'b0;
            check_regs($sformatf("rnd%0d", blk));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
